// File: rtl/alu_cmd_seq.sv
// Command sequencer feeding a 4-bit combinational ALU: command FIFO, registered result slot, accumulator.
// Optional ALU_CMD_STATS_EN adds saturating capture/carry counters (stat_ops, stat_carries).
module alu_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_opcode,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_opcode,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_carry,
  output logic         res_zero,
  output logic [W-1:0] acc,
  output logic         busy
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_carries
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q  [DEPTH];
  logic [2:0]    op_d  [DEPTH];
  logic [W-1:0]  a_q   [DEPTH];
  logic [W-1:0]  a_d   [DEPTH];
  logic [W-1:0]  b_q   [DEPTH];
  logic [W-1:0]  b_d   [DEPTH];
  logic          ua_q  [DEPTH];
  logic          ua_d  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  logic          res_zero_q, res_zero_d;
  logic          push, capture, head_valid;

  assign head_valid = (count_q != '0);
  assign cmd_ready  = (count_q != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;

  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (head_valid) begin
      alu_opcode = op_q[rd_ptr_q];
      alu_b      = b_q[rd_ptr_q];
      alu_a      = ua_q[rd_ptr_q] ? acc_q : a_q[rd_ptr_q];
    end
  end

  // RUN always has a free slot; STALL holds an undrained result and captures only
  // on the edge it drains, so throughput stays at one result per cycle.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      RUN:     capture = 1'b1;
      STALL:   capture = res_ready;
      default: capture = 1'b0;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    ua_d        = ua_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    if (push) begin
      op_d[wr_ptr_q] = cmd_opcode;
      a_d[wr_ptr_q]  = cmd_a;
      b_d[wr_ptr_q]  = cmd_b;
      ua_d[wr_ptr_q] = cmd_use_acc;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end
    if (res_ready)
      res_valid_d = 1'b0;
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_result;
      res_carry_d = alu_carry;
      res_zero_d  = alu_zero;
      acc_d       = alu_result;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(capture);
    if (count_d == '0)
      state_d = IDLE;
    else if (res_valid_d)
      state_d = STALL;
    else
      state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
        ua_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ua_q        <= ua_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign acc       = acc_q;
  assign busy      = head_valid || res_valid_q;

`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_carries_q, stat_carries_d;

  always_comb begin
    stat_ops_d     = stat_ops_q;
    stat_carries_d = stat_carries_q;
    if (capture && (stat_ops_q != '1))
      stat_ops_d = stat_ops_q + 16'd1;
    if (capture && alu_carry && (stat_carries_q != '1))
      stat_carries_d = stat_carries_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q     <= '0;
      stat_carries_q <= '0;
    end else begin
      stat_ops_q     <= stat_ops_d;
      stat_carries_q <= stat_carries_d;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_carries = stat_carries_q;
`endif

endmodule
